arbiter: RTL and testbench
==========================

ARBITER -- requirements
Module: arbiter

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset: clk input 1 (rising edge), rstn input 1 (async assert, sync release).
REQ-002 The block SHALL have per-master ports, N=1,2, all 1 bit: mN_breq in (bus request); mN_bgrant out (grant); mN_mode in (1=write, 0=read); mN_wr_bus in (serial addr/write bit); mN_master_valid in (master bit valid); mN_slave_ready out (bus ready for master bit); mN_rd_bus out (serial read bit); mN_slave_valid out (read bit valid); mN_master_ready in (master ready for read bit); mN_ack out (address-accepted pulse); mN_split out (transaction suspended by split).
REQ-003 The block SHALL have per-slave ports, X in {s1,s2,s3,bb}, all 1 bit: X_mode out; X_wr_bus out; X_master_valid out; X_slave_ready in; X_rd_bus in; X_slave_valid in; X_master_ready out.
REQ-004 The block SHALL have slave_split input 1 bit, driven by s2: 1 = s2 has suspended the current transaction.

Function
REQ-005 Bus SHALL be bit-serial, MSB first, one bit per valid&ready handshake.
REQ-006 Address map SHALL decode the 16-bit address: 0000xxxx -> s1 (low 11 bits, bit 11 ignored); 0001 -> s2 (low 12 bits); 0010 -> s3 (low 12 bits); 11xx -> bb (low 14 bits); all other prefixes unmapped.
REQ-007 States SHALL be IDLE, ADDR, FWD, DATA.
REQ-008 IDLE: on any breq sample, grant per priority (split-resume > m1 > m2); bgrant high the next cycle; latch mode; go ADDR (or DATA for split-resume).
REQ-009 ADDR: granted master's slave_ready=1; shift in 16 bits; after 16th accepted bit decode.
REQ-010 Unmapped address: drop bgrant next cycle, no ack, return IDLE; master must deassert breq.
REQ-011 FWD: replay the slave's low-order address bits (width per REQ-006) on X_wr_bus with X_master_valid, advancing on X_slave_ready; after last bit pulse mN_ack for exactly one cycle and enter DATA.
REQ-012 DATA: combinational pass-through between granted master and selected slave: wr_bus, master_valid, master_ready to slave; rd_bus, slave_ready, slave_valid to master; X_mode = latched mode throughout FWD and DATA.
REQ-013 Unselected slaves and ungranted masters SHALL see all arbiter outputs 0.
REQ-014 Transaction SHALL end when granted master deasserts breq: bgrant low next cycle, return IDLE; other master's pending request is then served.
REQ-015 Split: in DATA with s2 selected and slave_split=1, assert mN_split (held), drop mN_bgrant, record owner, mark s2 reserved, go IDLE.
REQ-016 While s2 reserved, the other master may be granted; if it decodes to s2, drop its bgrant without ack (as REQ-010 but request kept pending); it restarts from ADDR when regranted after reservation clears.
REQ-017 When slave_split=0 with reservation held and bus IDLE, regrant owner, clear mN_split in the same cycle, enter DATA with s2 selected (no address resend); clear reservation on completion per REQ-014.
REQ-018 Simultaneous breq from both masters SHALL grant m1; no preemption of an active grant except split.

Reset
REQ-019 rstn low SHALL force IDLE, clear shift register, selection, latched mode and split reservation, and drive every output 0, including mid-transaction.
REQ-020 After reset release, first grant SHALL occur no earlier than the cycle after breq is sampled.

Verification
REQ-021 m2 alone writes addr 0x1ABC data 0x5A -> m2_bgrant next cycle, s2 receives 12 bits 0xABC, one-cycle m2_ack, s2 receives 0x5A in write mode.
REQ-022 m1 and m2 breq same cycle -> m1_bgrant only; m2_bgrant the cycle after m1 drops breq and bus returns IDLE.
REQ-023 m1 reads s2 and slave_split rises -> m1_split=1, m1_bgrant=0; pending m2 is granted; slave_split falls -> m1 regranted, m1_split=0, read data equals previously written byte.
REQ-024 Address 0xC123 -> bb receives 14 bits 0x0123; address 0x07FF -> s1 receives 11 bits 0x7FF; address 0x5000 -> no ack, bgrant dropped next cycle.
REQ-025 rstn asserted during DATA -> all outputs 0 immediately; new transaction after release completes normally.

Source files
------------

// File: rtl/arbiter_if.sv
// Bundle of every master-side and slave-side serial bus signal of the arbiter.
// The arbiter connects through the slave modport; masters and slaves attach through master.
interface arbiter_if;
  logic m1_breq, m1_bgrant, m1_mode, m1_wr_bus, m1_master_valid, m1_slave_ready;
  logic m1_rd_bus, m1_slave_valid, m1_master_ready, m1_ack, m1_split;
  logic m2_breq, m2_bgrant, m2_mode, m2_wr_bus, m2_master_valid, m2_slave_ready;
  logic m2_rd_bus, m2_slave_valid, m2_master_ready, m2_ack, m2_split;

  logic s1_mode, s1_wr_bus, s1_master_valid, s1_slave_ready, s1_rd_bus, s1_slave_valid, s1_master_ready;
  logic s2_mode, s2_wr_bus, s2_master_valid, s2_slave_ready, s2_rd_bus, s2_slave_valid, s2_master_ready;
  logic s3_mode, s3_wr_bus, s3_master_valid, s3_slave_ready, s3_rd_bus, s3_slave_valid, s3_master_ready;
  logic bb_mode, bb_wr_bus, bb_master_valid, bb_slave_ready, bb_rd_bus, bb_slave_valid, bb_master_ready;

  logic slave_split;

  modport slave (
    input  m1_breq, m1_mode, m1_wr_bus, m1_master_valid, m1_master_ready,
    output m1_bgrant, m1_slave_ready, m1_rd_bus, m1_slave_valid, m1_ack, m1_split,
    input  m2_breq, m2_mode, m2_wr_bus, m2_master_valid, m2_master_ready,
    output m2_bgrant, m2_slave_ready, m2_rd_bus, m2_slave_valid, m2_ack, m2_split,
    output s1_mode, s1_wr_bus, s1_master_valid, s1_master_ready,
    input  s1_slave_ready, s1_rd_bus, s1_slave_valid,
    output s2_mode, s2_wr_bus, s2_master_valid, s2_master_ready,
    input  s2_slave_ready, s2_rd_bus, s2_slave_valid,
    output s3_mode, s3_wr_bus, s3_master_valid, s3_master_ready,
    input  s3_slave_ready, s3_rd_bus, s3_slave_valid,
    output bb_mode, bb_wr_bus, bb_master_valid, bb_master_ready,
    input  bb_slave_ready, bb_rd_bus, bb_slave_valid,
    input  slave_split
  );

  modport master (
    output m1_breq, m1_mode, m1_wr_bus, m1_master_valid, m1_master_ready,
    input  m1_bgrant, m1_slave_ready, m1_rd_bus, m1_slave_valid, m1_ack, m1_split,
    output m2_breq, m2_mode, m2_wr_bus, m2_master_valid, m2_master_ready,
    input  m2_bgrant, m2_slave_ready, m2_rd_bus, m2_slave_valid, m2_ack, m2_split,
    input  s1_mode, s1_wr_bus, s1_master_valid, s1_master_ready,
    output s1_slave_ready, s1_rd_bus, s1_slave_valid,
    input  s2_mode, s2_wr_bus, s2_master_valid, s2_master_ready,
    output s2_slave_ready, s2_rd_bus, s2_slave_valid,
    input  s3_mode, s3_wr_bus, s3_master_valid, s3_master_ready,
    output s3_slave_ready, s3_rd_bus, s3_slave_valid,
    input  bb_mode, bb_wr_bus, bb_master_valid, bb_master_ready,
    output bb_slave_ready, bb_rd_bus, bb_slave_valid,
    output slave_split
  );
endinterface

// File: rtl/arbiter.sv
// Two-master, four-slave bit-serial bus arbiter: serial address capture, decode,
// address replay to the selected slave, data pass-through and s2 split/resume.
module arbiter (
  input  logic     clk,
  input  logic     rstn,
  arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ADDR, FWD, DATA} state_t;

  localparam logic [1:0] SEL_S1 = 2'd0;
  localparam logic [1:0] SEL_S2 = 2'd1;
  localparam logic [1:0] SEL_S3 = 2'd2;
  localparam logic [1:0] SEL_BB = 2'd3;

  // Master inputs indexed [0]=m1 [1]=m2, slave inputs [0]=s1 [1]=s2 [2]=s3 [3]=bb
  logic [1:0] w_breq, w_mmode, w_mwr, w_mvalid, w_mready;
  logic [3:0] w_sready, w_srd, w_svalid;

  assign w_breq   = {bus.m2_breq,         bus.m1_breq};
  assign w_mmode  = {bus.m2_mode,         bus.m1_mode};
  assign w_mwr    = {bus.m2_wr_bus,       bus.m1_wr_bus};
  assign w_mvalid = {bus.m2_master_valid, bus.m1_master_valid};
  assign w_mready = {bus.m2_master_ready, bus.m1_master_ready};
  assign w_sready = {bus.bb_slave_ready, bus.s3_slave_ready, bus.s2_slave_ready, bus.s1_slave_ready};
  assign w_srd    = {bus.bb_rd_bus,      bus.s3_rd_bus,      bus.s2_rd_bus,      bus.s1_rd_bus};
  assign w_svalid = {bus.bb_slave_valid, bus.s3_slave_valid, bus.s2_slave_valid, bus.s1_slave_valid};

  state_t      r_state, w_state_nxt;
  logic        r_gnt, w_gnt_nxt;
  logic [1:0]  r_bgrant, w_bgrant_nxt;
  logic [1:0]  r_ack, w_ack_nxt;
  logic [1:0]  r_split, w_split_nxt;
  logic [1:0]  r_blocked, w_blocked_nxt;
  logic        r_mode, w_mode_nxt;
  logic        r_res_mode, w_res_mode_nxt;
  logic [15:0] r_shift, w_shift_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  r_sel, w_sel_nxt;
  logic        r_res, w_res_nxt;
  logic        r_owner, w_owner_nxt;
  logic        r_resumed, w_resumed_nxt;

  // Address decode sees the incoming 16th bit directly so it can act on that same edge
  logic [15:0] w_addr;
  logic        w_map_ok;
  logic [1:0]  w_map_sel;
  logic [3:0]  w_map_last;

  always_comb begin
    w_addr     = {r_shift[14:0], w_mwr[r_gnt]};
    w_map_ok   = 1'b1;
    w_map_sel  = SEL_S1;
    w_map_last = 4'd10;
    if (w_addr[15:12] == 4'b0000) begin
      w_map_sel  = SEL_S1;
      w_map_last = 4'd10;
    end else if (w_addr[15:12] == 4'b0001) begin
      w_map_sel  = SEL_S2;
      w_map_last = 4'd11;
    end else if (w_addr[15:12] == 4'b0010) begin
      w_map_sel  = SEL_S3;
      w_map_last = 4'd11;
    end else if (w_addr[15:14] == 2'b11) begin
      w_map_sel  = SEL_BB;
      w_map_last = 4'd13;
    end else begin
      w_map_ok   = 1'b0;
    end
  end

  // The split owner and masters bounced off the reserved s2 wait for the reservation to clear
  logic [1:0] w_elig;
  logic       w_pick;

  assign w_elig[0] = w_breq[0] && !r_blocked[0] && !(r_res && (r_owner == 1'b0));
  assign w_elig[1] = w_breq[1] && !r_blocked[1] && !(r_res && (r_owner == 1'b1));
  assign w_pick    = ~w_elig[0];

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_bgrant_nxt   = r_bgrant;
    w_ack_nxt      = '0;
    w_split_nxt    = r_split;
    w_blocked_nxt  = r_blocked;
    w_mode_nxt     = r_mode;
    w_res_mode_nxt = r_res_mode;
    w_shift_nxt    = r_shift;
    w_cnt_nxt      = r_cnt;
    w_sel_nxt      = r_sel;
    w_res_nxt      = r_res;
    w_owner_nxt    = r_owner;
    w_resumed_nxt  = r_resumed;
    unique case (r_state)
      IDLE: begin
        if (r_res && !bus.slave_split) begin
          w_gnt_nxt             = r_owner;
          w_bgrant_nxt[r_owner] = 1'b1;
          w_split_nxt[r_owner]  = 1'b0;
          w_sel_nxt             = SEL_S2;
          w_mode_nxt            = r_res_mode;
          w_resumed_nxt         = 1'b1;
          w_state_nxt           = DATA;
        end else if (w_elig != 2'b00) begin
          w_gnt_nxt            = w_pick;
          w_bgrant_nxt[w_pick] = 1'b1;
          w_mode_nxt           = w_mmode[w_pick];
          w_cnt_nxt            = '0;
          w_resumed_nxt        = 1'b0;
          w_state_nxt          = ADDR;
        end
      end
      ADDR: begin
        if (w_mvalid[r_gnt]) begin
          w_shift_nxt = w_addr;
          w_cnt_nxt   = r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            if (!w_map_ok) begin
              w_bgrant_nxt[r_gnt] = 1'b0;
              w_state_nxt         = IDLE;
            end else if (r_res && (w_map_sel == SEL_S2)) begin
              w_bgrant_nxt[r_gnt]  = 1'b0;
              w_blocked_nxt[r_gnt] = 1'b1;
              w_state_nxt          = IDLE;
            end else begin
              w_sel_nxt   = w_map_sel;
              w_cnt_nxt   = w_map_last;
              w_state_nxt = FWD;
            end
          end
        end
      end
      FWD: begin
        if (w_sready[r_sel]) begin
          if (r_cnt == 4'd0) begin
            w_ack_nxt[r_gnt] = 1'b1;
            w_state_nxt      = DATA;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
      end
      DATA: begin
        if (!w_breq[r_gnt]) begin
          w_bgrant_nxt[r_gnt] = 1'b0;
          w_state_nxt         = IDLE;
          if (r_resumed) begin
            w_res_nxt     = 1'b0;
            w_blocked_nxt = '0;
            w_resumed_nxt = 1'b0;
          end
        end else if ((r_sel == SEL_S2) && bus.slave_split) begin
          w_split_nxt[r_gnt]  = 1'b1;
          w_bgrant_nxt[r_gnt] = 1'b0;
          w_owner_nxt         = r_gnt;
          w_res_nxt           = 1'b1;
          w_res_mode_nxt      = r_mode;
          w_resumed_nxt       = 1'b0;
          w_state_nxt         = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_gnt      <= 1'b0;
      r_bgrant   <= '0;
      r_ack      <= '0;
      r_split    <= '0;
      r_blocked  <= '0;
      r_mode     <= 1'b0;
      r_res_mode <= 1'b0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_sel      <= SEL_S1;
      r_res      <= 1'b0;
      r_owner    <= 1'b0;
      r_resumed  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_bgrant   <= w_bgrant_nxt;
      r_ack      <= w_ack_nxt;
      r_split    <= w_split_nxt;
      r_blocked  <= w_blocked_nxt;
      r_mode     <= w_mode_nxt;
      r_res_mode <= w_res_mode_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sel      <= w_sel_nxt;
      r_res      <= w_res_nxt;
      r_owner    <= w_owner_nxt;
      r_resumed  <= w_resumed_nxt;
    end
  end

  logic [1:0] w_m_sready, w_m_rd, w_m_svalid;
  logic [3:0] w_s_mode, w_s_wr, w_s_mvalid, w_s_mready;

  always_comb begin
    w_m_sready = '0;
    w_m_rd     = '0;
    w_m_svalid = '0;
    w_s_mode   = '0;
    w_s_wr     = '0;
    w_s_mvalid = '0;
    w_s_mready = '0;
    unique case (r_state)
      ADDR: w_m_sready[r_gnt] = 1'b1;
      FWD: begin
        w_s_mode[r_sel]   = r_mode;
        w_s_wr[r_sel]     = r_shift[r_cnt];
        w_s_mvalid[r_sel] = 1'b1;
      end
      DATA: begin
        w_m_sready[r_gnt] = w_sready[r_sel];
        w_m_rd[r_gnt]     = w_srd[r_sel];
        w_m_svalid[r_gnt] = w_svalid[r_sel];
        w_s_mode[r_sel]   = r_mode;
        w_s_wr[r_sel]     = w_mwr[r_gnt];
        w_s_mvalid[r_sel] = w_mvalid[r_gnt];
        w_s_mready[r_sel] = w_mready[r_gnt];
      end
      default: ;
    endcase
  end

  assign bus.m1_bgrant      = r_bgrant[0];
  assign bus.m1_ack         = r_ack[0];
  assign bus.m1_split       = r_split[0];
  assign bus.m1_slave_ready = w_m_sready[0];
  assign bus.m1_rd_bus      = w_m_rd[0];
  assign bus.m1_slave_valid = w_m_svalid[0];
  assign bus.m2_bgrant      = r_bgrant[1];
  assign bus.m2_ack         = r_ack[1];
  assign bus.m2_split       = r_split[1];
  assign bus.m2_slave_ready = w_m_sready[1];
  assign bus.m2_rd_bus      = w_m_rd[1];
  assign bus.m2_slave_valid = w_m_svalid[1];

  assign bus.s1_mode         = w_s_mode[0];
  assign bus.s1_wr_bus       = w_s_wr[0];
  assign bus.s1_master_valid = w_s_mvalid[0];
  assign bus.s1_master_ready = w_s_mready[0];
  assign bus.s2_mode         = w_s_mode[1];
  assign bus.s2_wr_bus       = w_s_wr[1];
  assign bus.s2_master_valid = w_s_mvalid[1];
  assign bus.s2_master_ready = w_s_mready[1];
  assign bus.s3_mode         = w_s_mode[2];
  assign bus.s3_wr_bus       = w_s_wr[2];
  assign bus.s3_master_valid = w_s_mvalid[2];
  assign bus.s3_master_ready = w_s_mready[2];
  assign bus.bb_mode         = w_s_mode[3];
  assign bus.bb_wr_bus       = w_s_wr[3];
  assign bus.bb_master_valid = w_s_mvalid[3];
  assign bus.bb_master_ready = w_s_mready[3];
endmodule

// File: tb/tb_arbiter.sv
// Directed bench for arbiter: expected serial words are queued when stimulus is
// driven and compared by a monitor as the bits arrive at slaves or masters.
module tb_arbiter;
  logic clk;
  logic rstn;
  arbiter_if bus ();

  arbiter dut (.clk(clk), .rstn(rstn), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // dest: 0=s1 1=s2 2=s3 3=bb (write-side bits), 4=m1 5=m2 (read bits)
  typedef struct {
    int          dest;
    int          nbits;
    logic [15:0] value;
    logic        mode;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] all_outs();
    return {bus.m1_bgrant, bus.m1_slave_ready, bus.m1_rd_bus, bus.m1_slave_valid, bus.m1_ack, bus.m1_split,
            bus.m2_bgrant, bus.m2_slave_ready, bus.m2_rd_bus, bus.m2_slave_valid, bus.m2_ack, bus.m2_split,
            bus.s1_mode, bus.s1_wr_bus, bus.s1_master_valid, bus.s1_master_ready,
            bus.s2_mode, bus.s2_wr_bus, bus.s2_master_valid, bus.s2_master_ready,
            bus.s3_mode, bus.s3_wr_bus, bus.s3_master_valid, bus.s3_master_ready,
            bus.bb_mode, bus.bb_wr_bus, bus.bb_master_valid, bus.bb_master_ready};
  endfunction

  function automatic logic m_bgrant(input int m);
    return (m == 1) ? bus.m1_bgrant : bus.m2_bgrant;
  endfunction
  function automatic logic m_ack(input int m);
    return (m == 1) ? bus.m1_ack : bus.m2_ack;
  endfunction
  function automatic logic m_sready(input int m);
    return (m == 1) ? bus.m1_slave_ready : bus.m2_slave_ready;
  endfunction
  function automatic logic s_mready(input int x);
    case (x)
      0: return bus.s1_master_ready;
      1: return bus.s2_master_ready;
      2: return bus.s3_master_ready;
      default: return bus.bb_master_ready;
    endcase
  endfunction

  task automatic set_breq(input int m, input logic b, input logic mode);
    if (m == 1) begin bus.m1_breq = b; bus.m1_mode = mode; end
    else        begin bus.m2_breq = b; bus.m2_mode = mode; end
  endtask
  task automatic set_wr(input int m, input logic b, input logic v);
    if (m == 1) begin bus.m1_wr_bus = b; bus.m1_master_valid = v; end
    else        begin bus.m2_wr_bus = b; bus.m2_master_valid = v; end
  endtask
  task automatic set_mr(input int m, input logic r);
    if (m == 1) bus.m1_master_ready = r;
    else        bus.m2_master_ready = r;
  endtask
  task automatic set_s(input int x, input logic b, input logic v);
    case (x)
      0: begin bus.s1_rd_bus = b; bus.s1_slave_valid = v; end
      1: begin bus.s2_rd_bus = b; bus.s2_slave_valid = v; end
      2: begin bus.s3_rd_bus = b; bus.s3_slave_valid = v; end
      default: begin bus.bb_rd_bus = b; bus.bb_slave_valid = v; end
    endcase
  endtask

  task automatic send_bits(input int m, input logic [15:0] val, input int n);
    logic rdy;
    int   k;
    for (int i = n - 1; i >= 0; i--) begin
      set_wr(m, val[i], 1'b1);
      k = 0;
      do begin
        @(negedge clk);
        rdy = m_sready(m);
        @(posedge clk);
        #1;
        k++;
      end while (!rdy && k < 50);
      if (!rdy) check("master_hs_timeout", rdy, 1);
    end
    set_wr(m, 1'b0, 1'b0);
  endtask

  task automatic slave_send(input int x, input logic [15:0] val, input int n);
    logic rdy;
    int   k;
    for (int i = n - 1; i >= 0; i--) begin
      set_s(x, val[i], 1'b1);
      k = 0;
      do begin
        @(negedge clk);
        rdy = s_mready(x);
        @(posedge clk);
        #1;
        k++;
      end while (!rdy && k < 50);
      if (!rdy) check("slave_hs_timeout", rdy, 1);
    end
    set_s(x, 1'b0, 1'b0);
  endtask

  task automatic wait_ack(input int m);
    int k = 0;
    while (!m_ack(m) && k < 40) begin
      step();
      k++;
    end
    check("ack_seen", m_ack(m), 1);
    step();
    check("ack_one_cycle", m_ack(m), 0);
  endtask

  // Address, replay and data phase of a granted master
  task automatic xfer(input int m, input logic [15:0] addr, input int dest, input int abits,
                      input logic [15:0] aexp, input logic [7:0] data, input logic mode);
    sb.push_back('{dest, abits, aexp, mode});
    send_bits(m, addr, 16);
    wait_ack(m);
    if (mode) begin
      sb.push_back('{dest, 8, {8'h00, data}, mode});
      send_bits(m, {8'h00, data}, 8);
    end else begin
      sb.push_back('{m + 3, 8, {8'h00, data}, mode});
      set_mr(m, 1'b1);
      slave_send(dest, {8'h00, data}, 8);
      set_mr(m, 1'b0);
    end
  endtask

  logic [15:0] acc [6];
  int          cnt [6];

  always @(negedge clk) begin
    logic [5:0] hit;
    logic [5:0] bitv;
    logic [3:0] smode;
    hit   = {bus.m2_slave_valid & bus.m2_master_ready, bus.m1_slave_valid & bus.m1_master_ready,
             bus.bb_master_valid & bus.bb_slave_ready, bus.s3_master_valid & bus.s3_slave_ready,
             bus.s2_master_valid & bus.s2_slave_ready, bus.s1_master_valid & bus.s1_slave_ready};
    bitv  = {bus.m2_rd_bus, bus.m1_rd_bus, bus.bb_wr_bus, bus.s3_wr_bus, bus.s2_wr_bus, bus.s1_wr_bus};
    smode = {bus.bb_mode, bus.s3_mode, bus.s2_mode, bus.s1_mode};
    for (int d = 0; d < 6; d++) begin
      if (hit[d]) begin
        if (sb.size() == 0 || sb[0].dest != d) begin
          check("route", d, (sb.size() == 0) ? 15 : sb[0].dest);
        end else begin
          acc[d] = {acc[d][14:0], bitv[d]};
          cnt[d]++;
          if (d < 4 && smode[d] !== sb[0].mode) check("slave_mode", smode[d], sb[0].mode);
          if (cnt[d] == sb[0].nbits) begin
            check("serial_word", acc[d], sb[0].value);
            void'(sb.pop_front());
            acc[d] = '0;
            cnt[d] = 0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 6; d++) begin
      acc[d] = '0;
      cnt[d] = 0;
    end
    rstn = 1'b0;
    bus.slave_split = 1'b0;
    set_breq(1, 0, 0); set_breq(2, 0, 0);
    set_wr(1, 0, 0);   set_wr(2, 0, 0);
    set_mr(1, 0);      set_mr(2, 0);
    for (int x = 0; x < 4; x++) set_s(x, 0, 0);
    bus.s1_slave_ready = 1'b1; bus.s2_slave_ready = 1'b1;
    bus.s3_slave_ready = 1'b1; bus.bb_slave_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", all_outs(), 0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    check("idle_outs", all_outs(), 0);

    // m2 alone writes 0x1ABC / 0x5A to s2
    set_breq(2, 1, 1);
    check("m2_no_early_grant", m_bgrant(2), 0);
    step();
    check("m2_grant", m_bgrant(2), 1);
    xfer(2, 16'h1ABC, 1, 12, 16'h0ABC, 8'h5A, 1'b1);
    set_breq(2, 0, 1);
    step();
    check("m2_release", m_bgrant(2), 0);

    // simultaneous requests: m1 wins, m2 follows after the bus idles
    set_breq(1, 1, 1);
    set_breq(2, 1, 1);
    step();
    check("prio_m1", m_bgrant(1), 1);
    check("prio_m2_wait", m_bgrant(2), 0);
    xfer(1, 16'h2005, 2, 12, 16'h0005, 8'h3C, 1'b1);
    check("m2_still_wait", m_bgrant(2), 0);
    set_breq(1, 0, 1);
    step();
    check("m1_dropped", m_bgrant(1), 0);
    check("m2_idle_gap", m_bgrant(2), 0);
    step();
    check("m2_served", m_bgrant(2), 1);
    xfer(2, 16'h07FF, 0, 11, 16'h07FF, 8'hA5, 1'b1);
    set_breq(2, 0, 1);
    step();

    // bb decode, then an unmapped address
    set_breq(1, 1, 1);
    step();
    check("m1_grant_bb", m_bgrant(1), 1);
    xfer(1, 16'hC123, 3, 14, 16'h0123, 8'hF0, 1'b1);
    set_breq(1, 0, 1);
    step();
    set_breq(1, 1, 1);
    step();
    check("m1_grant_unmapped", m_bgrant(1), 1);
    send_bits(1, 16'h5000, 16);
    check("unmapped_drop", m_bgrant(1), 0);
    check("unmapped_no_ack", m_ack(1), 0);
    set_breq(1, 0, 1);
    step();
    check("unmapped_no_ack2", m_ack(1), 0);
    check("unmapped_idle", m_bgrant(1), 0);

    // split on an s2 read, other master served, s2 bounce, then resume
    set_breq(1, 1, 0);
    step();
    check("m1_grant_read", m_bgrant(1), 1);
    set_breq(2, 1, 1);
    sb.push_back('{1, 12, 16'h0ABC, 1'b0});
    send_bits(1, 16'h1ABC, 16);
    wait_ack(1);
    check("no_preempt", m_bgrant(2), 0);
    bus.slave_split = 1'b1;
    step();
    check("split_flag", bus.m1_split, 1);
    check("split_drop", m_bgrant(1), 0);
    step();
    check("m2_grant_during_split", m_bgrant(2), 1);
    xfer(2, 16'h2010, 2, 12, 16'h0010, 8'h11, 1'b1);
    set_breq(2, 0, 1);
    step();
    set_breq(2, 1, 1);
    step();
    check("m2_grant_s2_try", m_bgrant(2), 1);
    send_bits(2, 16'h1000, 16);
    check("reserved_drop", m_bgrant(2), 0);
    check("reserved_no_ack", m_ack(2), 0);
    step();
    step();
    check("reserved_blocked", m_bgrant(2), 0);
    check("owner_waits", m_bgrant(1), 0);
    bus.slave_split = 1'b0;
    step();
    check("resume_grant", m_bgrant(1), 1);
    check("resume_split_clr", bus.m1_split, 0);
    sb.push_back('{4, 8, 16'h005A, 1'b0});
    set_mr(1, 1'b1);
    slave_send(1, 16'h005A, 8);
    set_mr(1, 1'b0);
    set_breq(1, 0, 0);
    step();
    check("resume_done", m_bgrant(1), 0);
    step();
    check("m2_restart_grant", m_bgrant(2), 1);
    xfer(2, 16'h1000, 1, 12, 16'h0000, 8'h77, 1'b1);
    set_breq(2, 0, 1);
    step();

    // reset in the middle of a data phase
    set_breq(1, 1, 1);
    step();
    sb.push_back('{2, 12, 16'h0001, 1'b1});
    send_bits(1, 16'h2001, 16);
    wait_ack(1);
    sb.push_back('{2, 4, 16'h000A, 1'b1});
    send_bits(1, 16'h000A, 4);
    set_wr(1, 1'b1, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check("reset_mid_data", all_outs(), 0);
    set_breq(1, 0, 0);
    set_wr(1, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    set_breq(2, 1, 1);
    check("post_reset_no_early", m_bgrant(2), 0);
    step();
    check("post_reset_grant", m_bgrant(2), 1);
    xfer(2, 16'h0123, 0, 11, 16'h0123, 8'h42, 1'b1);
    set_breq(2, 0, 1);
    step();
    check("post_reset_release", m_bgrant(2), 0);

    repeat (2) step();
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
